multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/multicycle_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Bus bundle between the multicycle control FSM and its datapath/memories.
// The controller takes the master modport; the datapath side takes the slave modport.
interface multicycle_ctrl_if #(
  parameter int XLEN = 32
);
  logic            run;
  logic [XLEN-1:0] ir;
  logic            EQ;
  logic            imem_ready;
  logic            dmem_ready;
  logic            imem_req;
  logic            ir_we;
  logic            dmem_req;
  logic            dmem_we;
  logic            pc_we;
  logic            pc_src;
  logic            RegWrite;
  logic            ALUsrc;
  logic [2:0]      ALUctrl;
  logic [1:0]      ImmSrc;
  logic            result_src;
  logic            illegal;
  logic [XLEN-1:0] cycle_cnt;
  logic [XLEN-1:0] instret_cnt;

  modport master (
    input  run, ir, EQ, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, RegWrite,
           ALUsrc, ALUctrl, ImmSrc, result_src, illegal, cycle_cnt, instret_cnt
  );

  modport slave (
    output run, ir, EQ, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src, RegWrite,
           ALUsrc, ALUctrl, ImmSrc, result_src, illegal, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for an addi/add/bne/lw/sw subset, with cycle and
// retired-instruction counters.
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cycle_q, cycle_d;
  logic [XLEN-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_addi, is_add, is_bne, is_lw, is_sw, supported;
  logic       unused_ir;

  logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_src;
  logic       reg_write, alu_src, result_src, illegal;
  logic [2:0] alu_ctrl;
  logic [1:0] imm_src;

  assign opcode    = bus.ir[6:0];
  assign funct3    = bus.ir[14:12];
  assign funct7    = bus.ir[31:25];
  assign unused_ir = ^bus.ir;

  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_add    = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign is_bne    = (opcode == 7'b1100011) && (funct3 == 3'b001);
  assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
  assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
  assign supported = is_addi | is_add | is_bne | is_lw | is_sw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (bus.run && bus.imem_ready) state_d = DECODE;
      DECODE:  state_d = supported ? EXEC : FETCH;
      EXEC: begin
        if (is_addi || is_add)    state_d = WB;
        else if (is_lw || is_sw)  state_d = MEM;
        else                      state_d = FETCH;
      end
      MEM:     if (bus.dmem_ready) state_d = is_lw ? WB : FETCH;
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = 3'b000;
    imm_src    = 2'b00;
    result_src = 1'b0;
    illegal    = 1'b0;
    // No ALU output register: operand selection stays valid from EXEC through WB.
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      alu_src  = is_addi | is_lw | is_sw;
      alu_ctrl = is_bne ? 3'b001 : 3'b000;
      imm_src  = is_sw ? 2'b01 : (is_bne ? 2'b10 : 2'b00);
    end
    case (state_q)
      FETCH: begin
        imem_req = bus.run;
        ir_we    = bus.run & bus.imem_ready;
      end
      DECODE: begin
        illegal = ~supported;
        pc_we   = ~supported;
      end
      EXEC: begin
        pc_we  = is_bne;
        pc_src = is_bne & ~bus.EQ;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        pc_we    = is_sw & bus.dmem_ready;
      end
      WB: begin
        reg_write  = 1'b1;
        result_src = is_lw;
        pc_we      = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    cycle_d   = cycle_q + 1'b1;
    instret_d = instret_q;
    if (pc_we && !illegal) instret_d = instret_q + 1'b1;
  end

  // Enables are forced low while reset is held, even if the state was mid-access.
  assign bus.imem_req    = imem_req & ~rst;
  assign bus.ir_we       = ir_we & ~rst;
  assign bus.dmem_req    = dmem_req & ~rst;
  assign bus.dmem_we     = dmem_we & ~rst;
  assign bus.pc_we       = pc_we & ~rst;
  assign bus.RegWrite    = reg_write & ~rst;
  assign bus.illegal     = illegal & ~rst;
  assign bus.pc_src      = pc_src;
  assign bus.ALUsrc      = alu_src;
  assign bus.ALUctrl     = alu_ctrl;
  assign bus.ImmSrc      = imm_src;
  assign bus.result_src  = result_src;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

endmodule
